// File: rtl/calc_control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : calc_control_seq
//  Brief    : Key-sequencing controller for the calculator. Decodes one-cycle
//             key strobes into operand load/backspace, operator latch, ALU
//             execute and memory strobes, and tracks digits per operand.
//             Optional build macro CALC_CHAIN_EN enables operation chaining
//             (operator key while entering B evaluates and continues).
//  Revision : 1.0  initial release
// ============================================================================
module calc_control_seq #(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dig_in,
  input  logic             clr_in,
  input  logic             op_in,
  input  logic             ex_in,
  input  logic             bksp_in,
  input  logic             ms_in,
  input  logic             mr_in,
  input  logic             mc_in,
  input  logic             err_in,
  output logic             load_a,
  output logic             load_b,
  output logic             bksp_a,
  output logic             bksp_b,
  output logic             clr_ab,
  output logic             load_op,
  output logic             execute,
  output logic             res_to_a,
  output logic             mem_store,
  output logic             mem_recall,
  output logic             mem_clear,
  output logic             mem_valid,
  output logic [CNT_W-1:0] digit_count,
  output logic [1:0]       display_select
);

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    OP_WAIT = 3'd1,
    ENTRY_B = 3'd2,
    RESULT  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  // Winning key of the cycle after priority resolution
  typedef enum logic [3:0] {
    K_NONE = 4'd0,
    K_CLR  = 4'd1,
    K_EX   = 4'd2,
    K_OP   = 4'd3,
    K_MC   = 4'd4,
    K_MS   = 4'd5,
    K_MR   = 4'd6,
    K_BKSP = 4'd7,
    K_DIG  = 4'd8
  } key_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_valid_q, mem_valid_d;
  logic             exec_q;   // execute was issued last cycle; err_in is meaningful now
  key_t             key;

  // Resolve simultaneous key strobes to the single highest-priority key
  always_comb begin
    key = K_NONE;
    if      (clr_in)  key = K_CLR;
    else if (ex_in)   key = K_EX;
    else if (op_in)   key = K_OP;
    else if (mc_in)   key = K_MC;
    else if (ms_in)   key = K_MS;
    else if (mr_in)   key = K_MR;
    else if (bksp_in) key = K_BKSP;
    else if (dig_in)  key = K_DIG;
  end

  // State, digit counter, memory flag and execute-tracking registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ENTRY_A;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      exec_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      exec_q      <= execute;
    end
  end

  // Next-state and strobe decode from registered state and the winning key
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_valid_d = mem_valid_q;
    load_a      = 1'b0;
    load_b      = 1'b0;
    bksp_a      = 1'b0;
    bksp_b      = 1'b0;
    clr_ab      = 1'b0;
    load_op     = 1'b0;
    execute     = 1'b0;
    res_to_a    = 1'b0;
    mem_store   = 1'b0;
    mem_recall  = 1'b0;
    mem_clear   = 1'b0;

    if (key == K_CLR) begin
      clr_ab  = 1'b1;
      state_d = ENTRY_A;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ENTRY_A, ENTRY_B: begin
          case (key)
            K_EX: begin
              // Evaluate only once an operator and B have been entered
              if (state_q == ENTRY_B) begin
                execute = 1'b1;
                state_d = RESULT;
              end
            end
            K_OP: begin
              if (state_q == ENTRY_A) begin
                load_op = 1'b1;
                state_d = OP_WAIT;
                cnt_d   = '0;
              end else begin
`ifdef CALC_CHAIN_EN
                // Running calculation: fold A op B into A, take the new operator
                execute  = 1'b1;
                res_to_a = 1'b1;
                load_op  = 1'b1;
                state_d  = OP_WAIT;
                cnt_d    = '0;
`endif
              end
            end
            K_MC: begin
              mem_clear   = 1'b1;
              mem_valid_d = 1'b0;
            end
            K_MS: begin
              mem_store   = 1'b1;
              mem_valid_d = 1'b1;
            end
            K_MR: begin
              // A recalled value fills the operand; only backspace can edit it
              if (mem_valid_q) begin
                mem_recall = 1'b1;
                cnt_d      = MAX_CNT;
              end
            end
            K_BKSP: begin
              if (cnt_q != '0) begin
                bksp_a = (state_q == ENTRY_A);
                bksp_b = (state_q == ENTRY_B);
                cnt_d  = cnt_q - ONE_CNT;
              end
            end
            K_DIG: begin
              if (cnt_q < MAX_CNT) begin
                load_a = (state_q == ENTRY_A);
                load_b = (state_q == ENTRY_B);
                cnt_d  = cnt_q + ONE_CNT;
              end
            end
            default: ;
          endcase
        end
        OP_WAIT: begin
          // Memory keys, backspace and execute have no meaning before B starts
          case (key)
            K_OP: load_op = 1'b1;
            K_DIG: begin
              load_b  = 1'b1;
              state_d = ENTRY_B;
              cnt_d   = ONE_CNT;
            end
            default: ;
          endcase
        end
        RESULT: begin
          case (key)
            K_OP: begin
              res_to_a = 1'b1;
              load_op  = 1'b1;
              state_d  = OP_WAIT;
              cnt_d    = '0;
            end
            K_MC: begin
              mem_clear   = 1'b1;
              mem_valid_d = 1'b0;
            end
            K_MS: begin
              mem_store   = 1'b1;
              mem_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;  // ERROR: only clear is honoured, handled above
      endcase
    end

    // An ALU fault reported after an evaluation wins over any other move
    if (exec_q && err_in) begin
      state_d = ERROR;
    end
  end

  // Display source depends on state alone
  always_comb begin
    case (state_q)
      ENTRY_B: display_select = 2'b01;
      RESULT:  display_select = 2'b10;
      ERROR:   display_select = 2'b11;
      default: display_select = 2'b00;
    endcase
  end

  assign mem_valid   = mem_valid_q;
  assign digit_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_control_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_calc_control_seq
//  Brief    : Self-checking bench for calc_control_seq (MAX_DIGITS=4).
//             Expected strobes and registered outputs are queued per key step
//             and compared when the DUT responds.
//  Revision : 1.0  initial release
// ============================================================================
module tb_calc_control_seq;

  // Key vector order: {clr, ex, op, mc, ms, mr, bksp, dig}
  localparam logic [7:0] K_0    = 8'h00;
  localparam logic [7:0] K_CLR  = 8'h80;
  localparam logic [7:0] K_EX   = 8'h40;
  localparam logic [7:0] K_OP   = 8'h20;
  localparam logic [7:0] K_MC   = 8'h10;
  localparam logic [7:0] K_MS   = 8'h08;
  localparam logic [7:0] K_MR   = 8'h04;
  localparam logic [7:0] K_BK   = 8'h02;
  localparam logic [7:0] K_DIG  = 8'h01;

  // Strobe vector order: {load_a, load_b, bksp_a, bksp_b, clr_ab, load_op,
  //                       execute, res_to_a, mem_store, mem_recall, mem_clear}
  localparam logic [10:0] S_0   = 11'h000;
  localparam logic [10:0] S_LA  = 11'h400;
  localparam logic [10:0] S_LB  = 11'h200;
  localparam logic [10:0] S_BA  = 11'h100;
  localparam logic [10:0] S_BB  = 11'h080;
  localparam logic [10:0] S_CLR = 11'h040;
  localparam logic [10:0] S_LOP = 11'h020;
  localparam logic [10:0] S_EXE = 11'h010;
  localparam logic [10:0] S_RTA = 11'h008;
  localparam logic [10:0] S_MS  = 11'h004;
  localparam logic [10:0] S_MR  = 11'h002;
  localparam logic [10:0] S_MC  = 11'h001;

  typedef struct {
    logic [10:0] s;
    logic [2:0]  c;
    logic [1:0]  ds;
    logic        mv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dig_in, clr_in, op_in, ex_in, bksp_in, ms_in, mr_in, mc_in, err_in;
  logic        load_a, load_b, bksp_a, bksp_b, clr_ab, load_op, execute, res_to_a;
  logic        mem_store, mem_recall, mem_clear, mem_valid;
  logic [2:0]  digit_count;
  logic [1:0]  display_select;
  logic [10:0] w_strobes;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;

  always #5 clk = ~clk;

  assign w_strobes = {load_a, load_b, bksp_a, bksp_b, clr_ab, load_op,
                      execute, res_to_a, mem_store, mem_recall, mem_clear};

  calc_control_seq #(.MAX_DIGITS(4), .CNT_W(3)) dut (
    .clock          (clk),
    .reset          (rst),
    .dig_in         (dig_in),
    .clr_in         (clr_in),
    .op_in          (op_in),
    .ex_in          (ex_in),
    .bksp_in        (bksp_in),
    .ms_in          (ms_in),
    .mr_in          (mr_in),
    .mc_in          (mc_in),
    .err_in         (err_in),
    .load_a         (load_a),
    .load_b         (load_b),
    .bksp_a         (bksp_a),
    .bksp_b         (bksp_b),
    .clr_ab         (clr_ab),
    .load_op        (load_op),
    .execute        (execute),
    .res_to_a       (res_to_a),
    .mem_store      (mem_store),
    .mem_recall     (mem_recall),
    .mem_clear      (mem_clear),
    .mem_valid      (mem_valid),
    .digit_count    (digit_count),
    .display_select (display_select)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] k, input logic e);
    {clr_in, ex_in, op_in, mc_in, ms_in, mr_in, bksp_in, dig_in} = k;
    err_in = e;
  endtask

  // One key cycle: queue expectations, check strobes mid-low-phase,
  // then check registered outputs just after the edge.
  task automatic step(input logic [7:0] k, input logic e, input logic [10:0] s,
                      input logic [2:0] c, input logic [1:0] ds, input logic mv);
    exp_t x;
    @(negedge clk);
    drive(k, e);
    exp_q.push_back('{s: s, c: c, ds: ds, mv: mv});
    n_step++;
    #2;
    x = exp_q.pop_front();
    chk($sformatf("strobes@%0d", n_step), 32'(w_strobes), 32'(x.s));
    @(posedge clk);
    #1;
    chk($sformatf("count@%0d", n_step), 32'(digit_count), 32'(x.c));
    chk($sformatf("dsel@%0d", n_step), 32'(display_select), 32'(x.ds));
    chk($sformatf("memv@%0d", n_step), 32'(mem_valid), 32'(x.mv));
  endtask

  initial begin
    rst = 1'b1;
    drive(K_0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 32'(w_strobes), 32'(S_0));
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_dsel", 32'(display_select), 32'd0);
    chk("rst_memv", 32'(mem_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Digit limit and backspace floor on operand A
    for (int i = 1; i <= 4; i++) step(K_DIG, 0, S_LA, 3'(i), 2'b00, 0);
    step(K_DIG, 0, S_0, 3'd4, 2'b00, 0);
    for (int i = 3; i >= 0; i--) step(K_BK, 0, S_BA, 3'(i), 2'b00, 0);
    step(K_BK, 0, S_0, 3'd0, 2'b00, 0);
    step(K_0, 1, S_0, 3'd0, 2'b00, 0);             // err_in without execute: no effect

    // A op B B =
    step(K_DIG, 0, S_LA,  3'd1, 2'b00, 0);
    step(K_EX,  0, S_0,   3'd1, 2'b00, 0);         // execute ignored in ENTRY_A
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 0);
    step(K_EX | K_BK | K_MS, 0, S_0, 3'd0, 2'b00, 0); // OP_WAIT ignores these
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 0);         // operator replaced
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 0);
    step(K_DIG, 0, S_LB,  3'd2, 2'b01, 0);
    step(K_EX,  0, S_EXE, 3'd2, 2'b10, 0);

    // Memory handling
    step(K_DIG, 0, S_0,   3'd2, 2'b10, 0);         // digit ignored in RESULT
    step(K_MR,  0, S_0,   3'd2, 2'b10, 0);         // recall ignored in RESULT
    step(K_MS,  0, S_MS,  3'd2, 2'b10, 1);
    step(K_CLR, 0, S_CLR, 3'd0, 2'b00, 1);
    step(K_MR,  0, S_MR,  3'd4, 2'b00, 1);
    step(K_DIG, 0, S_0,   3'd4, 2'b00, 1);         // operand full after recall
    step(K_MC,  0, S_MC,  3'd4, 2'b00, 0);
    step(K_MR,  0, S_0,   3'd4, 2'b00, 0);
    step(K_BK,  0, S_BA,  3'd3, 2'b00, 0);
    step(K_MS | K_MR | K_DIG, 0, S_MS, 3'd3, 2'b00, 1); // ms outranks mr and dig

    // ALU error path
    step(K_CLR, 0, S_CLR, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LA,  3'd1, 2'b00, 1);
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_EX,  0, S_EXE, 3'd1, 2'b10, 1);
    step(K_0,   1, S_0,   3'd1, 2'b11, 1);
    step(K_DIG, 0, S_0,   3'd1, 2'b11, 1);
    step(K_OP,  0, S_0,   3'd1, 2'b11, 1);
    step(K_EX,  0, S_0,   3'd1, 2'b11, 1);
    step(K_MC,  0, S_0,   3'd1, 2'b11, 1);
    step(K_CLR, 0, S_CLR, 3'd0, 2'b00, 1);

    // Priority and backspace-to-empty inside ENTRY_B
    step(K_DIG, 0, S_LA,  3'd1, 2'b00, 1);
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_BK,  0, S_BB,  3'd0, 2'b01, 1);
    step(K_BK,  0, S_0,   3'd0, 2'b01, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_CLR | K_EX, 0, S_CLR, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LA,  3'd1, 2'b00, 1);
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_EX | K_OP | K_DIG, 0, S_EXE, 3'd1, 2'b10, 1);
    step(K_OP,  0, S_RTA | S_LOP, 3'd0, 2'b00, 1); // result becomes A
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);

    // Operator key while entering B
`ifdef CALC_CHAIN_EN
    step(K_OP,  0, S_EXE | S_RTA | S_LOP, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_OP,  0, S_EXE | S_RTA | S_LOP, 3'd0, 2'b00, 1);
    step(K_0,   1, S_0,   3'd0, 2'b11, 1);         // error beats OP_WAIT
    step(K_CLR, 0, S_CLR, 3'd0, 2'b00, 1);
`else
    step(K_OP,  0, S_0,   3'd1, 2'b01, 1);
    step(K_DIG, 0, S_LB,  3'd2, 2'b01, 1);
    step(K_CLR, 0, S_CLR, 3'd0, 2'b00, 1);
`endif

    // Asynchronous reset between edges from RESULT with memory set
    step(K_DIG, 0, S_LA,  3'd1, 2'b00, 1);
    step(K_OP,  0, S_LOP, 3'd0, 2'b00, 1);
    step(K_DIG, 0, S_LB,  3'd1, 2'b01, 1);
    step(K_EX,  0, S_EXE, 3'd1, 2'b10, 1);
    @(negedge clk);
    drive(K_0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_strobes", 32'(w_strobes), 32'(S_0));
    chk("arst_count", 32'(digit_count), 32'd0);
    chk("arst_dsel", 32'(display_select), 32'd0);
    chk("arst_memv", 32'(mem_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(K_DIG, 0, S_LA, 3'd1, 2'b00, 0);

    @(negedge clk);
    drive(K_0, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_control_seq.md
Name: calc_control_seq

Overview:
- Parametrised next-generation key-sequencing controller for the calculator.
- Decodes single-cycle key strobes (digit, operator, execute, clear, backspace, memory keys) into datapath load, backspace, execute and memory strobes, plus a display select.
- Sits between the keypad edge detectors and the operand/ALU/memory datapath.
- Adds over the previous controller:
  - per-operand digit limit with a digit counter;
  - working memory-key handling (MS/MR/MC);
  - an error state;
  - optional operation chaining.

Parameters:
- MAX_DIGITS, 4, maximum digits per operand; further digit keys are ignored.
- CNT_W, 3, width of digit_count; must satisfy 2**CNT_W > MAX_DIGITS.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dig_in  in  1  digit key strobe.
- clr_in  in  1  clear key strobe.
- op_in  in  1  operator key strobe.
- ex_in  in  1  execute (=) key strobe.
- bksp_in  in  1  backspace strobe.
- ms_in  in  1  memory store strobe.
- mr_in  in  1  memory recall strobe.
- mc_in  in  1  memory clear strobe.
- err_in  in  1  ALU error (overflow, divide by zero); valid in the cycle after execute.
- load_a, load_b  out  1 each  shift a digit into operand A or B.
- bksp_a, bksp_b  out  1 each  remove last digit of A or B.
- clr_ab  out  1  clear both operand registers.
- load_op  out  1  latch operator.
- execute  out  1  ALU evaluate; result is registered on the same edge.
- res_to_a  out  1  copy result into A.
- mem_store, mem_recall, mem_clear  out  1 each  memory strobes; recall targets the register chosen by display_select.
- mem_valid  out  1  memory holds a stored value.
- digit_count  out  CNT_W  digits in the operand currently being entered.
- display_select  out  2  00=A, 01=B, 10=result, 11=error.

Behaviour:
- States: ENTRY_A, OP_WAIT, ENTRY_B, RESULT, ERROR. State is registered on the clock.
- Output timing:
  - Strobes are combinational from the registered state and the current inputs, at most one action per cycle.
  - display_select is a function of state only: ENTRY_A/OP_WAIT 00, ENTRY_B 01, RESULT 10, ERROR 11.
- Input priority when several strobes are high in one cycle: clr > ex > op > mc > ms > mr > bksp > dig. Lower-priority inputs are ignored that cycle.
- Reset values:
  - state=ENTRY_A, digit_count=0, mem_valid=0.
  - All strobes 0; display_select=00.
- Error entry:
  - err_in high in the cycle after execute -> ERROR on the next edge, overriding any other transition.
  - In ERROR, only clr_in is acted on; all other keys produce no strobes.
- clr_in, any state: pulse clr_ab; go to ENTRY_A; digit_count=0. mem_valid is unaffected.
- ENTRY_A:
  - dig: load_a and digit_count+1, only if digit_count<MAX_DIGITS; otherwise ignored.
  - bksp: bksp_a and digit_count-1, only if digit_count>0.
  - op: load_op -> OP_WAIT, digit_count=0.
- OP_WAIT:
  - dig: load_b -> ENTRY_B, digit_count=1.
  - op: load_op (replaces operator); stay.
  - bksp and ex are ignored.
- ENTRY_B:
  - dig and bksp as in ENTRY_A, using load_b and bksp_b.
  - ex: execute -> RESULT.
  - If bksp takes digit_count to 0, the state stays ENTRY_B.
- RESULT:
  - op: res_to_a and load_op -> OP_WAIT, digit_count=0.
  - dig and bksp are ignored.
- Memory keys (any state except ERROR and OP_WAIT):
  - ms: mem_store; mem_valid=1.
  - mc: mem_clear; mem_valid=0.
  - mr, ENTRY_A/ENTRY_B, only if mem_valid: mem_recall; digit_count=MAX_DIGITS (operand full; only backspace may edit it).
  - mr in RESULT or with mem_valid=0 is ignored.
- Async reset asserted mid-operation immediately forces the reset values, independent of clock.

Optional Feature:
- CALC_CHAIN_EN defined: op_in in ENTRY_B pulses execute, res_to_a and load_op in the same cycle, then goes to OP_WAIT with digit_count=0. This gives running calculations (A op B op C ...).
- If err_in follows that execute, ERROR takes priority over OP_WAIT.
- Not defined: op_in in ENTRY_B is ignored.

Test Plan:
- After reset, digits 1,2,3,4,5 (MAX_DIGITS=4) -> load_a pulses 4 times, digit_count=4, the fifth digit produces no strobe; bksp x5 -> 4 bksp_a pulses, digit_count=0.
- dig, op, dig, dig, ex -> load_a, load_op, load_b (ENTRY_B, count=1), load_b (count=2), execute; display_select=10.
- In RESULT, ms -> mem_store, mem_valid=1; clr; mr -> mem_recall, digit_count=4, display_select=00; mc -> mem_valid=0; a further mr -> no strobe.
- execute followed by err_in=1 -> display_select=11; dig, op, ex ignored; clr -> ENTRY_A, clr_ab pulse, mem_valid unchanged.
- Same cycle clr_in=1 and ex_in=1 in ENTRY_B -> clr_ab only, no execute; reset asserted between edges -> outputs zero immediately.
- With CALC_CHAIN_EN: A, op, B, op -> execute, res_to_a and load_op in one cycle, state OP_WAIT; without it, the second op produces no strobe and the state stays ENTRY_B.
